// File: rtl/fetch_pkg.sv
// Shared fetch-side types: field widths and the fetch queue entry.
// Consumed by the fetch/decode queue and its storage array.
package fetch_pkg;

   localparam int ADDR_W = 40;
   localparam int INST_W = 32;
   localparam int DATA_W = 64;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
      logic              xcpt;
      logic [DATA_W-1:0] xcpt_cause;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_decode_queue_mem.sv
// Entry storage for the fetch/decode queue.
// One synchronous write port, one asynchronous read port, no reset.
module fetch_decode_queue_mem
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  fetch_entry_t  wdata,
   input  logic [AW-1:0] raddr,
   output fetch_entry_t  rdata
);

   fetch_entry_t mem [DEPTH];

   always_ff @(posedge CLK) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// In-order instruction queue between fetch and decode.
// Optional same-cycle empty-queue bypass: define FETCH_QUEUE_BYPASS_EN.
module fetch_decode_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = fetch_pkg::ADDR_W,
   parameter int INST_W = fetch_pkg::INST_W,
   parameter int DATA_W = fetch_pkg::DATA_W
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       FLUSH,
   input  logic                       lock,
   input  logic [ADDR_W-1:0]          PC_FROM_FETCH,
   input  logic                       PC_VALID_FROM_FETCH,
   input  logic [INST_W-1:0]          INST_FROM_FETCH,
   input  logic                       FETCH_XCPT,
   input  logic [DATA_W-1:0]          FETCH_XCPT_CAUSE,
   output logic                       QUEUE_READY_TO_FETCH,
   output logic [ADDR_W-1:0]          PC_TO_DECODE,
   output logic                       PC_VALID_TO_DEC,
   output logic [INST_W-1:0]          INST_TO_DECODE,
   output logic                       XCPT_TO_DECODE,
   output logic [DATA_W-1:0]          XCPT_CAUSE_TO_DECODE,
   output logic [$clog2(DEPTH+1)-1:0] QUEUE_COUNT
);

   import fetch_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_n;
   logic          rdy_q;
   logic          empty;
   logic          push;
   logic          pop;
   logic          byp;
   fetch_entry_t  wr_ent;
   fetch_entry_t  rd_ent;
   fetch_entry_t  head;

   assign empty = (cnt == '0);

   always_comb begin
      wr_ent            = '0;
      wr_ent.pc         = PC_FROM_FETCH;
      wr_ent.inst       = FETCH_XCPT ? '0 : INST_FROM_FETCH;
      wr_ent.xcpt       = FETCH_XCPT;
      wr_ent.xcpt_cause = FETCH_XCPT_CAUSE;
   end

`ifdef FETCH_QUEUE_BYPASS_EN
   // rdy_q keeps the bypass quiet while reset is still settling
   assign byp = empty & PC_VALID_FROM_FETCH & rdy_q & ~FLUSH;
`else
   assign byp = 1'b0;
`endif

   assign push = PC_VALID_FROM_FETCH & rdy_q & ~FLUSH
               & ~(byp & ~lock);
   assign pop  = ~empty & ~lock & ~FLUSH;

   always_comb begin
      cnt_n = cnt;
      if (FLUSH)
         cnt_n = '0;
      else begin
         unique case ({push, pop})
            2'b10:   cnt_n = cnt + CW'(1);
            2'b01:   cnt_n = cnt - CW'(1);
            default: cnt_n = cnt;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         rdy_q  <= 1'b0;
      end else begin
         cnt   <= cnt_n;
         rdy_q <= (cnt_n != CW'(DEPTH));
         if (FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + AW'(1);
            if (pop)
               rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end

   fetch_decode_queue_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .CLK   (CLK),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (wr_ent),
      .raddr (rd_ptr),
      .rdata (rd_ent)
   );

   always_comb begin
      head = '0;
      if (!empty)
         head = rd_ent;
      else if (byp)
         head = wr_ent;
   end

   assign QUEUE_READY_TO_FETCH = rdy_q;
   assign PC_VALID_TO_DEC      = ~empty | byp;
   assign PC_TO_DECODE         = head.pc;
   assign INST_TO_DECODE       = head.inst;
   assign XCPT_TO_DECODE       = head.xcpt;
   assign XCPT_CAUSE_TO_DECODE = head.xcpt_cause;
   assign QUEUE_COUNT          = cnt;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: vector table, directed corners,
// and random traffic against a queue-based reference model.
module tb_fetch_decode_queue;

   localparam int DEPTH = 4;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        FLUSH = 1'b0;
   logic        lock = 1'b0;
   logic [39:0] PC_FROM_FETCH = '0;
   logic        PC_VALID_FROM_FETCH = 1'b0;
   logic [31:0] INST_FROM_FETCH = '0;
   logic        FETCH_XCPT = 1'b0;
   logic [63:0] FETCH_XCPT_CAUSE = '0;
   logic        QUEUE_READY_TO_FETCH;
   logic [39:0] PC_TO_DECODE;
   logic        PC_VALID_TO_DEC;
   logic [31:0] INST_TO_DECODE;
   logic        XCPT_TO_DECODE;
   logic [63:0] XCPT_CAUSE_TO_DECODE;
   logic [2:0]  QUEUE_COUNT;

   fetch_decode_queue #(.DEPTH(DEPTH)) dut (
      .CLK                  (CLK),
      .RST                  (RST),
      .FLUSH                (FLUSH),
      .lock                 (lock),
      .PC_FROM_FETCH        (PC_FROM_FETCH),
      .PC_VALID_FROM_FETCH  (PC_VALID_FROM_FETCH),
      .INST_FROM_FETCH      (INST_FROM_FETCH),
      .FETCH_XCPT           (FETCH_XCPT),
      .FETCH_XCPT_CAUSE     (FETCH_XCPT_CAUSE),
      .QUEUE_READY_TO_FETCH (QUEUE_READY_TO_FETCH),
      .PC_TO_DECODE         (PC_TO_DECODE),
      .PC_VALID_TO_DEC      (PC_VALID_TO_DEC),
      .INST_TO_DECODE       (INST_TO_DECODE),
      .XCPT_TO_DECODE       (XCPT_TO_DECODE),
      .XCPT_CAUSE_TO_DECODE (XCPT_CAUSE_TO_DECODE),
      .QUEUE_COUNT          (QUEUE_COUNT)
   );

   always #5 CLK = ~CLK;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [39:0] pc;
      logic [31:0] inst;
      logic        x;
      logic [63:0] c;
   } ent_t;

   ent_t q[$];
   bit   rdy_m = 1'b0;
   bit   exp_rdy_s;
   bit   byp_s;

   typedef struct {
      logic        lock;
      logic        valid;
      logic [39:0] pc;
      logic        ev;
      logic [39:0] epc;
      int          ecnt;
      logic        erdy;
   } vec_t;

   vec_t tv[10];

   function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endfunction

   function automatic ent_t mk(logic [39:0] pc, logic [31:0] ins,
                               logic x, logic [63:0] c);
      ent_t e;
      e.pc   = pc;
      e.inst = x ? 32'h0 : ins;
      e.x    = x;
      e.c    = c;
      return e;
   endfunction

   // drive one cycle's inputs and check the head against the model
   task automatic pre(input logic fl, input logic lk, input logic v,
                      input logic [39:0] pc, input logic [31:0] ins,
                      input logic x, input logic [63:0] c);
      ent_t e;
      logic ev;
      @(negedge CLK);
      FLUSH = fl;
      lock = lk;
      PC_VALID_FROM_FETCH = v;
      PC_FROM_FETCH = pc;
      INST_FROM_FETCH = ins;
      FETCH_XCPT = x;
      FETCH_XCPT_CAUSE = c;
      #1;
      e = mk(40'h0, 32'h0, 1'b0, 64'h0);
      ev = 1'b0;
      exp_rdy_s = rdy_m && (q.size() != DEPTH);
      byp_s = BYP && (q.size() == 0) && v && rdy_m && !fl;
      if (q.size() != 0) begin
         e = q[0];
         ev = 1'b1;
      end else if (byp_s) begin
         e = mk(pc, ins, x, c);
         ev = 1'b1;
      end
      chk("valid", 64'(PC_VALID_TO_DEC), 64'(ev));
      chk("pc", 64'(PC_TO_DECODE), 64'(e.pc));
      chk("inst", 64'(INST_TO_DECODE), 64'(e.inst));
      chk("xcpt", 64'(XCPT_TO_DECODE), 64'(e.x));
      chk("cause", XCPT_CAUSE_TO_DECODE, e.c);
      chk("count", 64'(QUEUE_COUNT), 64'(q.size()));
      chk("ready", 64'(QUEUE_READY_TO_FETCH), 64'(exp_rdy_s));
   endtask

   task automatic post();
      bit used;
      @(posedge CLK);
      used = 1'b0;
      if (FLUSH)
         q.delete();
      else begin
         if (!lock) begin
            if (q.size() != 0)
               void'(q.pop_front());
            else if (byp_s)
               used = 1'b1;
         end
         if (PC_VALID_FROM_FETCH && exp_rdy_s && !used)
            q.push_back(mk(PC_FROM_FETCH, INST_FROM_FETCH,
                           FETCH_XCPT, FETCH_XCPT_CAUSE));
      end
      rdy_m = 1'b1;
   endtask

   task automatic idle(input logic lk);
      pre(1'b0, lk, 1'b0, 40'h0, 32'h0, 1'b0, 64'h0);
      post();
   endtask

   task automatic put(input logic lk, input logic [39:0] pc);
      pre(1'b0, lk, 1'b1, pc, {16'hA5A5, pc[15:0]}, 1'b0, 64'h0);
      post();
   endtask

   logic [39:0] npc;
   int          pushed;
   logic        r_fl;
   logic        r_lk;
   logic        r_v;
   logic        r_x;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tv[0] = '{1'b1, 1'b1, 40'h2000, BYP, BYP ? 40'h2000 : 40'h0, 0, 1'b1};
      tv[1] = '{1'b1, 1'b1, 40'h2004, 1'b1, 40'h2000, 1, 1'b1};
      tv[2] = '{1'b1, 1'b1, 40'h2008, 1'b1, 40'h2000, 2, 1'b1};
      tv[3] = '{1'b1, 1'b1, 40'h200C, 1'b1, 40'h2000, 3, 1'b1};
      tv[4] = '{1'b1, 1'b1, 40'h2010, 1'b1, 40'h2000, 4, 1'b0};
      tv[5] = '{1'b0, 1'b0, 40'h0, 1'b1, 40'h2000, 4, 1'b0};
      tv[6] = '{1'b0, 1'b0, 40'h0, 1'b1, 40'h2004, 3, 1'b1};
      tv[7] = '{1'b0, 1'b0, 40'h0, 1'b1, 40'h2008, 2, 1'b1};
      tv[8] = '{1'b0, 1'b0, 40'h0, 1'b1, 40'h200C, 1, 1'b1};
      tv[9] = '{1'b0, 1'b0, 40'h0, 1'b0, 40'h0, 0, 1'b1};

      // reset held with fetch presenting an entry
      PC_VALID_FROM_FETCH = 1'b1;
      PC_FROM_FETCH = 40'h1234;
      repeat (2) @(negedge CLK);
      #1;
      chk("rst_ready", 64'(QUEUE_READY_TO_FETCH), 64'h0);
      chk("rst_valid", 64'(PC_VALID_TO_DEC), 64'h0);
      chk("rst_pc", 64'(PC_TO_DECODE), 64'h0);
      chk("rst_count", 64'(QUEUE_COUNT), 64'h0);
      PC_VALID_FROM_FETCH = 1'b0;
      @(posedge CLK);
      #2 RST = 1'b1;
      idle(1'b0);

      // three back-to-back pushes drained without stall
      put(1'b0, 40'h1000);
      put(1'b0, 40'h1004);
      put(1'b0, 40'h1008);
      idle(1'b0);
      idle(1'b0);

      // fill under lock, refused fifth push, drain
      for (int i = 0; i < 10; i++) begin
         pre(1'b0, tv[i].lock, tv[i].valid, tv[i].pc,
             {16'hA5A5, tv[i].pc[15:0]}, 1'b0, 64'h0);
         chk("tbl_valid", 64'(PC_VALID_TO_DEC), 64'(tv[i].ev));
         chk("tbl_pc", 64'(PC_TO_DECODE), 64'(tv[i].epc));
         chk("tbl_count", 64'(QUEUE_COUNT), 64'(tv[i].ecnt));
         chk("tbl_ready", 64'(QUEUE_READY_TO_FETCH), 64'(tv[i].erdy));
         post();
      end

      // full queue with simultaneous pop and push, past wrap-around
      for (int i = 0; i < 4; i++)
         put(1'b1, 40'h5000 + 40'(4 * i));
      npc = 40'h5010;
      pushed = 4;
      pre(1'b0, 1'b0, 1'b1, npc, 32'h1, 1'b0, 64'h0);
      chk("full_cnt4", 64'(QUEUE_COUNT), 64'd4);
      chk("full_rdy0", 64'(QUEUE_READY_TO_FETCH), 64'd0);
      post();
      pre(1'b0, 1'b0, 1'b1, npc, 32'h1, 1'b0, 64'h0);
      chk("full_cnt3", 64'(QUEUE_COUNT), 64'd3);
      chk("full_head", 64'(PC_TO_DECODE), 64'h5004);
      post();
      pushed += 1;
      npc += 40'd4;
      while (pushed < 12) begin
         pre(1'b0, 1'b0, 1'b1, npc, 32'(npc), 1'b0, 64'h0);
         post();
         if (exp_rdy_s) begin
            pushed += 1;
            npc += 40'd4;
         end
      end
      repeat (5) idle(1'b0);

      // fetch exception zeroes the instruction
      pre(1'b0, 1'b1, 1'b1, 40'h6000, 32'hDEADBEEF, 1'b1, 64'hC);
      post();
      pre(1'b0, 1'b1, 1'b0, 40'h0, 32'h0, 1'b0, 64'h0);
      chk("xc_inst", 64'(INST_TO_DECODE), 64'h0);
      chk("xc_flag", 64'(XCPT_TO_DECODE), 64'h1);
      chk("xc_cause", XCPT_CAUSE_TO_DECODE, 64'hC);
      chk("xc_pc", 64'(PC_TO_DECODE), 64'h6000);
      post();
      idle(1'b0);
      idle(1'b0);

      // flush with three queued and a concurrent push
      put(1'b1, 40'h7000);
      put(1'b1, 40'h7004);
      put(1'b1, 40'h7008);
      pre(1'b1, 1'b0, 1'b1, 40'h700C, 32'h77, 1'b0, 64'h0);
      post();
      pre(1'b0, 1'b0, 1'b0, 40'h0, 32'h0, 1'b0, 64'h0);
      chk("fl_count", 64'(QUEUE_COUNT), 64'h0);
      chk("fl_valid", 64'(PC_VALID_TO_DEC), 64'h0);
      chk("fl_pc", 64'(PC_TO_DECODE), 64'h0);
      post();
      idle(1'b0);

`ifdef FETCH_QUEUE_BYPASS_EN
      pre(1'b0, 1'b0, 1'b1, 40'h8000, 32'h88, 1'b0, 64'h0);
      chk("byp_valid", 64'(PC_VALID_TO_DEC), 64'h1);
      chk("byp_pc", 64'(PC_TO_DECODE), 64'h8000);
      chk("byp_count", 64'(QUEUE_COUNT), 64'h0);
      post();
      pre(1'b0, 1'b0, 1'b0, 40'h0, 32'h0, 1'b0, 64'h0);
      chk("byp_gone", 64'(PC_VALID_TO_DEC), 64'h0);
      chk("byp_cnt0", 64'(QUEUE_COUNT), 64'h0);
      post();
`endif

      // random traffic
      for (int i = 0; i < 400; i++) begin
         r_fl = ($urandom_range(0, 19) == 0);
         r_lk = ($urandom_range(0, 9) < 4);
         r_v  = ($urandom_range(0, 9) < 7);
         r_x  = ($urandom_range(0, 9) == 0);
         pre(r_fl, r_lk, r_v, {8'($urandom), $urandom}, $urandom,
             r_x, {$urandom, $urandom});
         post();
      end

      // asynchronous reset with two entries queued
      idle(1'b0);
      put(1'b1, 40'h9000);
      put(1'b1, 40'h9004);
      PC_VALID_FROM_FETCH = 1'b0;
      #3 RST = 1'b0;
      #1;
      chk("arst_valid", 64'(PC_VALID_TO_DEC), 64'h0);
      chk("arst_pc", 64'(PC_TO_DECODE), 64'h0);
      chk("arst_count", 64'(QUEUE_COUNT), 64'h0);
      chk("arst_ready", 64'(QUEUE_READY_TO_FETCH), 64'h0);
      q.delete();
      rdy_m = 1'b0;
      @(posedge CLK);
      #2 RST = 1'b1;
      idle(1'b0);
      put(1'b0, 40'hA000);
      idle(1'b0);
      idle(1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
